// File: rtl/prim_reg_sw_port.sv
// rtl/prim_reg_sw_port.sv - register-bus request to one-hot subreg we/re pulse and response
// Optional macro: PRIM_REG_SW_PORT_BE_CHECK_EN (writes with partial byte enables become errors)
module prim_reg_sw_port #(
    parameter int NumRegs = 8,
    parameter int DW      = 32,
    parameter int AW      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DW-1:0]         req_wdata_i,
    input  logic [DW/8-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wd_o,
    input  logic [NumRegs*DW-1:0] reg_qs_i
);

    localparam int IW = AW - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e               r_state;
    logic                 r_err;
    logic [NumRegs-1:0]   r_we;
    logic [NumRegs-1:0]   r_re;
    logic [DW-1:0]        r_wd;
    logic [DW-1:0]        r_rdata;
    logic                 r_rsp_valid;
    logic                 r_rsp_error;

    logic [IW-1:0]        w_idx;
    logic                 w_accept;
    logic                 w_be_err;
    logic                 w_err;
    logic [NumRegs-1:0]   w_onehot;
    logic [DW-1:0]        w_rd;

    assign w_idx    = req_addr_i[AW-1:2];
    assign w_accept = req_valid_i && (r_state == S_IDLE);

`ifdef PRIM_REG_SW_PORT_BE_CHECK_EN
    assign w_be_err = req_write_i && (req_be_i != {(DW/8){1'b1}});
`else
    logic w_unused_be;
    assign w_unused_be = ^req_be_i;
    assign w_be_err    = 1'b0;
`endif

    assign w_err    = (|req_addr_i[1:0]) || (int'(w_idx) >= NumRegs) || w_be_err;
    assign w_onehot = NumRegs'(1) << w_idx;

    // r_re is one-hot only for a legal read, so this mux yields 0 for writes and errors
    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NumRegs; k++) begin
            if (r_re[k]) w_rd = w_rd | reg_qs_i[k*DW +: DW];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_err       <= 1'b0;
            r_we        <= '0;
            r_re        <= '0;
            r_wd        <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_we <= '0;
                    r_re <= '0;
                    if (w_accept) begin
                        r_err   <= w_err;
                        r_we    <= (req_write_i && !w_err) ? w_onehot : '0;
                        r_re    <= (!req_write_i && !w_err) ? w_onehot : '0;
                        if (req_write_i) r_wd <= req_wdata_i;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_we        <= '0;
                    r_re        <= '0;
                    r_rdata     <= w_rd;
                    r_rsp_error <= r_err;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_we        <= '0;
                    r_re        <= '0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rdata;
    assign rsp_error_o = r_rsp_error;
    assign reg_we_o    = r_we;
    assign reg_re_o    = r_re;
    assign reg_wd_o    = r_wd;

endmodule

// File: tb/tb_prim_reg_sw_port.sv
// tb/tb_prim_reg_sw_port.sv - directed and randomized checks of prim_reg_sw_port against a register-file model
module tb_prim_reg_sw_port;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic         req_write_i = 1'b0;
    logic [7:0]   req_addr_i = '0;
    logic [31:0]  req_wdata_i = '0;
    logic [3:0]   req_be_i = '0;
    logic         rsp_valid_o;
    logic         rsp_ready_i = 1'b0;
    logic [31:0]  rsp_rdata_o;
    logic         rsp_error_o;
    logic [7:0]   reg_we_o;
    logic [7:0]   reg_re_o;
    logic [31:0]  reg_wd_o;
    logic [255:0] reg_qs_i;

    logic [31:0]  mem [8];
    logic [31:0]  model_wd = '0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk_i = ~clk_i;

    always_comb begin
        reg_qs_i = '0;
        for (int k = 0; k < 8; k++) reg_qs_i[k*32 +: 32] = mem[k];
    end

    prim_reg_sw_port #(.NumRegs(8), .DW(32), .AW(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_error_o (rsp_error_o),
        .reg_we_o    (reg_we_o),
        .reg_re_o    (reg_re_o),
        .reg_wd_o    (reg_wd_o),
        .reg_qs_i    (reg_qs_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
        check({tag, "_rdata"},     64'(rsp_rdata_o), 64'(0));
        check({tag, "_error"},     64'(rsp_error_o), 64'(0));
        check({tag, "_we"},        64'(reg_we_o),    64'(0));
        check({tag, "_re"},        64'(reg_re_o),    64'(0));
        check({tag, "_wd"},        64'(reg_wd_o),    64'(0));
    endtask

    // Entered and left at a negedge; hold = cycles rsp_ready_i is kept low in RESP
    task automatic do_access(input string tag, input logic wr, input logic [7:0] addr,
                             input logic [31:0] wd, input logic [3:0] be, input int hold);
        logic        err;
        logic [5:0]  idx;
        logic [7:0]  exp_we;
        logic [7:0]  exp_re;
        logic [31:0] exp_rdata;
        idx = addr[7:2];
        err = (addr[1:0] != 2'b00) || (idx >= 6'd8);
`ifdef PRIM_REG_SW_PORT_BE_CHECK_EN
        if (wr && be != 4'hF) err = 1'b1;
`endif
        exp_we    = (wr && !err)  ? (8'd1 << idx) : 8'd0;
        exp_re    = (!wr && !err) ? (8'd1 << idx) : 8'd0;
        exp_rdata = (!wr && !err) ? mem[idx[2:0]] : 32'd0;
        if (wr) model_wd = wd;

        check({tag, "_ready_idle"}, 64'(req_ready_o), 64'(1));
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_be_i    = be;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_wdata_i = $urandom;
        check({tag, "_we"},        64'(reg_we_o),    64'(exp_we));
        check({tag, "_re"},        64'(reg_re_o),    64'(exp_re));
        check({tag, "_wd"},        64'(reg_wd_o),    64'(model_wd));
        check({tag, "_acc_valid"}, 64'(rsp_valid_o), 64'(0));
        check({tag, "_acc_ready"}, 64'(req_ready_o), 64'(0));
        if (wr && !err) mem[idx[2:0]] = wd;
        @(negedge clk_i);
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) rsp_ready_i = 1'b1;
            else if (hold > 0) req_valid_i = 1'b1;
            check({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(1));
            check({tag, "_rsp_rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
            check({tag, "_rsp_error"}, 64'(rsp_error_o), 64'(err));
            check({tag, "_rsp_we"},    64'(reg_we_o | reg_re_o), 64'(0));
            check({tag, "_rsp_ready"}, 64'(req_ready_o), 64'(0));
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
        check({tag, "_done_valid"}, 64'(rsp_valid_o), 64'(0));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mem[k] = 32'h1000_0000 + k;
        #1;
        check_idle_outputs("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("reset_ready", 64'(req_ready_o), 64'(1));

        do_access("t1_write",   1'b1, 8'h0C, 32'hDEAD_BEEF, 4'hF, 0);
        mem[3] = 32'h0000_1234;
        do_access("t2_read",    1'b0, 8'h0C, 32'h0, 4'hF, 0);
        do_access("t3_idx8",    1'b0, 8'h20, 32'h0, 4'hF, 0);
        do_access("t3_unalign", 1'b0, 8'h05, 32'h0, 4'hF, 0);
        do_access("t3_wr_oob",  1'b1, 8'hFC, 32'h5555_AAAA, 4'hF, 0);
        do_access("t4_hold",    1'b0, 8'h1C, 32'h0, 4'hF, 5);
        do_access("t4_next",    1'b1, 8'h00, 32'h0BAD_F00D, 4'hF, 0);
        do_access("t6_be",      1'b1, 8'h08, 32'hCAFE_0007, 4'b0111, 0);
        do_access("t6_be_rd",   1'b0, 8'h08, 32'h0, 4'b0001, 0);

        // Reset during the ACCESS cycle of a write
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 8'h10;
        req_wdata_i = 32'h7777_7777;
        req_be_i    = 4'hF;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check("t5_we_before", 64'(reg_we_o), 64'(8'h10));
        rst_ni = 1'b0;
        #1;
        model_wd = '0;
        check_idle_outputs("t5_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("t5_no_rsp", 64'(rsp_valid_o), 64'(0));
            check("t5_ready",  64'(req_ready_o), 64'(1));
        end
        do_access("t5_after", 1'b0, 8'h10, 32'h0, 4'hF, 0);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 39));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_access("rand", 1'($urandom), a, $urandom,
                      ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                      int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
